isa_sequencer: RTL and testbench
================================

ISA_SEQUENCER -- requirements
Module: isa_sequencer

Interface
REQ-001 SHALL have parameter IMEM_DEPTH, default 16, number of 20-bit instruction slots (power of two, 2..256).
REQ-002 SHALL have parameter SETTLE_CYCLES, default 2, cycles the datapath is given after issue before its output is sampled (1..15).
REQ-003 SHALL have parameter HALT_WORD, default 20'hFFFFF, instruction encoding that stops execution.
REQ-004 Ports, in order:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- load_we  in  1  instruction-memory write strobe.
- load_addr  in  $clog2(IMEM_DEPTH)  write address.
- load_data  in  20  instruction word to write.
- start  in  1  one-cycle run request.
- dp_result  in  32  datapath output (ISA `salida`).
- instr_out  out  20  instruction driven to the datapath.
- instr_valid  out  1  one-cycle issue strobe.
- result  out  32  last captured datapath output.
- result_valid  out  1  one-cycle capture strobe.
- pc  out  $clog2(IMEM_DEPTH)  current instruction index.
- busy  out  1  high from start acceptance until done.
- done  out  1  one-cycle end-of-program strobe.

Function
REQ-005 FSM states SHALL be IDLE, FETCH, ISSUE, WAIT, CAPTURE, DONE.
REQ-006 IDLE: load_we SHALL write load_data to imem[load_addr]; start SHALL clear pc to 0 and move to FETCH.
REQ-007 FETCH SHALL register imem[pc] into the instruction register; if the word equals HALT_WORD, next state SHALL be DONE, else ISSUE.
REQ-008 ISSUE SHALL assert instr_valid for exactly one cycle; instr_out SHALL hold the instruction register value from ISSUE through CAPTURE.
REQ-009 WAIT SHALL last exactly SETTLE_CYCLES cycles, counted by a down-counter loaded on ISSUE.
REQ-010 CAPTURE SHALL load result from dp_result and pulse result_valid for one cycle; if pc == IMEM_DEPTH-1, next state SHALL be DONE, else pc increments and next state SHALL be FETCH.
REQ-011 Per-instruction latency SHALL be 3+SETTLE_CYCLES cycles (FETCH to CAPTURE inclusive); result_valid of instruction n SHALL follow start by n*(3+SETTLE_CYCLES)+3+SETTLE_CYCLES cycles.
REQ-012 DONE SHALL pulse done for one cycle and return to IDLE; busy SHALL be high in every state except IDLE.
REQ-013 load_we and start SHALL be ignored while busy; pc SHALL never wrap.
REQ-014 Simultaneous load_we and start in IDLE SHALL perform the write and accept the start; FETCH SHALL see the written word.
REQ-015 HALT_WORD at imem[0] SHALL produce done with no instr_valid and no result_valid.
REQ-016 result SHALL hold its value between captures and across DONE/IDLE.

Reset
REQ-017 rst SHALL force IDLE; pc=0, instr_out=0, instr_valid=0, result=0, result_valid=0, busy=0, done=0.
REQ-018 rst mid-run SHALL abort at the next edge with no further strobes; imem contents SHALL NOT be reset.

Configuration
REQ-019 With ISA_SEQ_STEP_EN defined, an input port step (1 bit) SHALL be added after start, and a PAUSE state SHALL follow CAPTURE (when not ending) until a step pulse moves it to FETCH; rst SHALL exit PAUSE to IDLE.
REQ-020 Without ISA_SEQ_STEP_EN, port step and state PAUSE SHALL not exist; execution SHALL run continuously.

Structure
REQ-021 Shared package isa_pkg SHALL hold the state enum, instruction width (20), result width (32) and default HALT_WORD.
REQ-022 Instruction memory SHALL be a sub-module isa_imem (synchronous write, combinational read); FSM, counters and capture stay in isa_sequencer.

Verification
REQ-023 Load 3 words (20'h11C87, 20'h09D81, HALT_WORD), start -> 2 instr_valid, 2 result_valid 5 cycles apart (SETTLE=2), done on the cycle after HALT FETCH, pc=2.
REQ-024 HALT_WORD at imem[0], start -> done 2 cycles after start, no strobes, result unchanged.
REQ-025 All 16 slots non-halt -> 16 captures, done after pc=15, pc does not wrap.
REQ-026 rst asserted during WAIT of instruction 1 -> all outputs 0 next cycle, imem retained; rerun gives identical results.
REQ-027 start and load_we while busy -> ignored; load_we+start same cycle in IDLE to address 0 -> written word issued first.
REQ-028 ISA_SEQ_STEP_EN build: FSM parks in PAUSE after each capture; each step pulse advances exactly one instruction.

Source files
------------

// File: rtl/isa_pkg.sv
// Purpose: shared types and constants for the ISA program sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Optional macro ISA_SEQ_STEP_EN adds the PAUSE state used for single-stepping.
package isa_pkg;

    localparam int INSTR_W  = 20;
    localparam int RESULT_W = 32;

    // Encoding that terminates a program when fetched.
    localparam logic [INSTR_W-1:0] HALT_WORD_DEF = 20'hFFFFF;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        ISSUE   = 3'd2,
        WAIT    = 3'd3,
        CAPTURE = 3'd4,
        DONE    = 3'd5
`ifdef ISA_SEQ_STEP_EN
        ,PAUSE  = 3'd6
`endif
    } state_t;

endpackage

// File: rtl/isa_imem.sv
// Purpose: instruction store for the sequencer; synchronous write, combinational read.
// Latency: write visible to the read port on the cycle after the write edge; read is 0-cycle.
// Backpressure: none; writes always accepted when we is high.
// Ports: clk; we/waddr/wdata write port; raddr/rdata asynchronous read port.
// Contents are deliberately not reset so a program survives a sequencer reset.
module isa_imem
    import isa_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       we,
    input  logic [$clog2(DEPTH)-1:0]   waddr,
    input  logic [INSTR_W-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0]   raddr,
    output logic [INSTR_W-1:0]         rdata
);

    logic [INSTR_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // DEPTH is a power of two, so every address is in range.
    assign rdata = mem[raddr];

endmodule

// File: rtl/isa_sequencer.sv
// Purpose: steps through a loaded program, issuing each word to a datapath and capturing its output.
// Latency: 3+SETTLE_CYCLES cycles per instruction (FETCH..CAPTURE); done 2 cycles after start on an immediate HALT.
// Backpressure: none; load_we and start are dropped while busy (optional step pulse gates each instruction).
// Ports: clk, rst (sync, active high); load_we/load_addr/load_data program write (IDLE only);
//        start run request; [step, only with ISA_SEQ_STEP_EN]; dp_result datapath output;
//        instr_out/instr_valid issue; result/result_valid capture; pc, busy, done status.
module isa_sequencer
    import isa_pkg::*;
#(
    parameter int                 IMEM_DEPTH    = 16,
    parameter int                 SETTLE_CYCLES = 2,
    parameter logic [INSTR_W-1:0] HALT_WORD     = HALT_WORD_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          load_we,
    input  logic [$clog2(IMEM_DEPTH)-1:0] load_addr,
    input  logic [INSTR_W-1:0]            load_data,
    input  logic                          start,
`ifdef ISA_SEQ_STEP_EN
    input  logic                          step,
`endif
    input  logic [RESULT_W-1:0]           dp_result,
    output logic [INSTR_W-1:0]            instr_out,
    output logic                          instr_valid,
    output logic [RESULT_W-1:0]           result,
    output logic                          result_valid,
    output logic [$clog2(IMEM_DEPTH)-1:0] pc,
    output logic                          busy,
    output logic                          done
);

    localparam int AW = $clog2(IMEM_DEPTH);

    state_t             state;
    state_t             state_nx;
    logic [3:0]         settle_cnt;
    logic [INSTR_W-1:0] imem_rdata;
    logic               imem_we;
    logic               last_slot;

    // Programming is only possible while the sequencer is idle.
    assign imem_we   = load_we && (state == IDLE);
    assign last_slot = (pc == AW'(IMEM_DEPTH - 1));

    isa_imem #(
        .DEPTH (IMEM_DEPTH)
    ) u_imem (
        .clk   (clk),
        .we    (imem_we),
        .waddr (load_addr),
        .wdata (load_data),
        .raddr (pc),
        .rdata (imem_rdata)
    );

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = FETCH;
            FETCH:   state_nx = (imem_rdata == HALT_WORD) ? DONE : ISSUE;
            ISSUE:   state_nx = WAIT;
            // settle_cnt was loaded with SETTLE_CYCLES on ISSUE, so WAIT lasts exactly that many cycles.
            WAIT:    if (settle_cnt == 4'd1) state_nx = CAPTURE;
            CAPTURE: begin
                if (last_slot) begin
                    state_nx = DONE;
                end else begin
`ifdef ISA_SEQ_STEP_EN
                    state_nx = PAUSE;
`else
                    state_nx = FETCH;
`endif
                end
            end
            DONE:    state_nx = IDLE;
`ifdef ISA_SEQ_STEP_EN
            PAUSE:   if (step) state_nx = FETCH;
`endif
            default: state_nx = IDLE;
        endcase
    end

    // Strobes and busy are registered from the next state so each one is aligned
    // with the state it belongs to; result is loaded on the same edge as result_valid
    // so the captured value and its strobe appear together during CAPTURE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            pc           <= '0;
            instr_out    <= '0;
            settle_cnt   <= '0;
            result       <= '0;
            instr_valid  <= 1'b0;
            result_valid <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            state        <= state_nx;
            instr_valid  <= (state_nx == ISSUE);
            result_valid <= (state_nx == CAPTURE);
            done         <= (state_nx == DONE);
            busy         <= (state_nx != IDLE);

            if (state == IDLE && start) begin
                pc <= '0;
            end else if (state == CAPTURE && !last_slot) begin
                pc <= pc + AW'(1);
            end

            if (state == FETCH) begin
                instr_out <= imem_rdata;
            end

            if (state == ISSUE) begin
                settle_cnt <= 4'(SETTLE_CYCLES);
            end else if (state == WAIT) begin
                settle_cnt <= settle_cnt - 4'd1;
            end

            if (state_nx == CAPTURE) begin
                result <= dp_result;
            end
        end
    end

endmodule

// File: tb/tb_isa_sequencer.sv
`timescale 1ns/1ps
module tb_isa_sequencer;
    import isa_pkg::*;

    localparam int          DEPTH  = 16;
    localparam int          SETTLE = 2;
    localparam int          LAT    = 3 + SETTLE;
    localparam logic [19:0] HALT   = 20'hFFFFF;

    logic        clk = 1'b0;
    logic        rst, load_we, start;
    logic [3:0]  load_addr;
    logic [19:0] load_data;
    logic [31:0] dp_result;
`ifdef ISA_SEQ_STEP_EN
    logic        step;
`endif
    logic [19:0] instr_out;
    logic        instr_valid;
    logic [31:0] result;
    logic        result_valid;
    logic [3:0]  pc;
    logic        busy, done;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    logic [19:0] exp_w [DEPTH];

    typedef struct {
        string       name;
        int          n;          // non-halt words before HALT (DEPTH = no HALT)
        int          exp_done;   // done cycle relative to the start cycle
        int          exp_pc;
        logic [31:0] exp_final;  // result value seen on the done cycle
    } vec_t;
    vec_t vecs [4];

    isa_sequencer #(
        .IMEM_DEPTH    (DEPTH),
        .SETTLE_CYCLES (SETTLE),
        .HALT_WORD     (HALT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .load_we      (load_we),
        .load_addr    (load_addr),
        .load_data    (load_data),
        .start        (start),
`ifdef ISA_SEQ_STEP_EN
        .step         (step),
`endif
        .dp_result    (dp_result),
        .instr_out    (instr_out),
        .instr_valid  (instr_valid),
        .result       (result),
        .result_valid (result_valid),
        .pc           (pc),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Program word for slot i (never equal to HALT).
    function automatic logic [19:0] fw(input int i);
        if (i == 0) return 20'h11C87;
        if (i == 1) return 20'h09D81;
        return 20'h10000 + 20'(i) * 20'h00111;
    endfunction

    // Datapath stand-in: a fixed scramble of the issued instruction.
    function automatic logic [31:0] gd(input logic [19:0] w);
        return {w[11:0], w} ^ 32'h5A5A_0000;
    endfunction

    assign dp_result = gd(instr_out);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, expv);
        end
    endtask

    task automatic wr(input int a, input logic [19:0] d);
        @(negedge clk);
        load_we   = 1'b1;
        load_addr = a[3:0];
        load_data = d;
        @(negedge clk);
        load_we   = 1'b0;
    endtask

    task automatic load_prog(input int n);
        for (int i = 0; i < n; i++) begin
            wr(i, fw(i));
            exp_w[i] = fw(i);
        end
        if (n < DEPTH) wr(n, HALT);
    endtask

    // Waits (bounded) for a strobe: 0 instr_valid, 1 result_valid, 2 done.
    task automatic wait_for(input int which, input int base, output int rel);
        rel = -1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if ((which == 0 && instr_valid) || (which == 1 && result_valid) ||
                (which == 2 && done)) begin
                rel = cyc - base;
                break;
            end
        end
    endtask

    // Starts a run and monitors it to done. inj >= 0 drives start+load_we to
    // slot 1 at that relative cycle (must be ignored); co_load writes co_word
    // to slot 0 in the same cycle as start.
    task automatic run_prog(input string nm, input int n_ins, input int exp_done,
                            input int exp_pc, input logic [31:0] exp_final,
                            input int inj, input bit co_load, input logic [19:0] co_word);
        int c0, niv, nrv, rel, done_rel;
        bit busy_ok;
        @(negedge clk);
        start = 1'b1;
        if (co_load) begin
            load_we   = 1'b1;
            load_addr = 4'd0;
            load_data = co_word;
        end
        c0 = cyc;
        niv = 0; nrv = 0; done_rel = -1; busy_ok = 1'b1;
        for (int k = 0; k < 400 && done_rel < 0; k++) begin
            @(negedge clk);
            start   = 1'b0;
            load_we = 1'b0;
            rel = cyc - c0;
            if (rel == inj) begin
                start     = 1'b1;
                load_we   = 1'b1;
                load_addr = 4'd1;
                load_data = 20'h0BEEF;
            end
            if (!busy) busy_ok = 1'b0;
            if (instr_valid) niv++;
            if (result_valid) begin
                chk({nm, "_rv_cycle"}, rel, LAT * (nrv + 1));
                if (nrv < DEPTH) chk({nm, "_result"}, result, gd(exp_w[nrv]));
                nrv++;
            end
            if (done) begin
                done_rel = rel;
                chk({nm, "_pc"}, 32'(pc), exp_pc);
                chk({nm, "_final_result"}, result, exp_final);
            end
        end
        start   = 1'b0;
        load_we = 1'b0;
        chk({nm, "_done_cycle"}, done_rel, exp_done);
        chk({nm, "_instr_valid_count"}, niv, n_ins);
        chk({nm, "_result_valid_count"}, nrv, n_ins);
        chk({nm, "_busy_during_run"}, 32'(busy_ok), 1);
        @(negedge clk);
        chk({nm, "_idle_after_done"}, {30'd0, busy, done}, 0);
    endtask

    initial begin
        int c0, r;
        bit strobe_seen;

        rst = 1'b1; load_we = 1'b0; start = 1'b0;
        load_addr = '0; load_data = '0;
`ifdef ISA_SEQ_STEP_EN
        step = 1'b0;
`endif
        repeat (3) @(negedge clk);
        chk("rst_instr_out", 32'(instr_out), 0);
        chk("rst_instr_valid", 32'(instr_valid), 0);
        chk("rst_result", result, 0);
        chk("rst_result_valid", 32'(result_valid), 0);
        chk("rst_pc", 32'(pc), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        rst = 1'b0;

`ifdef ISA_SEQ_STEP_EN
        load_prog(2);
        @(negedge clk); start = 1'b1; c0 = cyc;
        @(negedge clk); start = 1'b0;
        wait_for(1, c0, r);
        chk("step_first_capture", r, LAT);
        chk("step_first_result", result, gd(fw(0)));
        strobe_seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (instr_valid || result_valid || done) strobe_seen = 1'b1;
        end
        chk("step_parked_no_strobe", 32'(strobe_seen), 0);
        chk("step_parked_busy", 32'(busy), 1);
        step = 1'b1; c0 = cyc;
        @(negedge clk); step = 1'b0;
        wait_for(0, c0, r);
        chk("step1_issue_cycle", r, 2);
        wait_for(1, c0, r);
        chk("step1_capture_cycle", r, 1 + LAT);
        chk("step1_result", result, gd(fw(1)));
        step = 1'b1; c0 = cyc;
        @(negedge clk); step = 1'b0;
        wait_for(2, c0, r);
        chk("step2_done_cycle", r, 2);
        chk("step2_pc", 32'(pc), 2);
`else
        vecs[0] = '{"two_plus_halt", 2, 2 * LAT + 2, 2, gd(fw(1))};
        vecs[1] = '{"halt_first", 0, 2, 0, gd(fw(1))};
        vecs[2] = '{"one_plus_halt", 1, LAT + 2, 1, gd(fw(0))};
        vecs[3] = '{"full_no_halt", DEPTH, DEPTH * LAT + 1, DEPTH - 1, gd(fw(DEPTH - 1))};

        for (int v = 0; v < 4; v++) begin
            load_prog(vecs[v].n);
            run_prog(vecs[v].name, vecs[v].n, vecs[v].exp_done, vecs[v].exp_pc,
                     vecs[v].exp_final, -1, 1'b0, 20'h0);
        end

        // Reset during WAIT of instruction 1, then rerun the retained program.
        load_prog(2);
        @(negedge clk); start = 1'b1; c0 = cyc;
        @(negedge clk); start = 1'b0;
        while (cyc - c0 < LAT + 3) @(negedge clk);
        chk("pre_abort_busy", 32'(busy), 1);
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        chk("abort_outputs_zero",
            {instr_out, instr_valid, result_valid, pc, busy, done, 6'd0}, 0);
        chk("abort_result_zero", result, 0);
        strobe_seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (instr_valid || result_valid || done || busy) strobe_seen = 1'b1;
        end
        chk("abort_quiet", 32'(strobe_seen), 0);
        run_prog("rerun_after_abort", 2, 2 * LAT + 2, 2, gd(fw(1)), -1, 1'b0, 20'h0);

        // start/load_we while busy must be ignored.
        run_prog("busy_ignore", 2, 2 * LAT + 2, 2, gd(fw(1)), 3, 1'b0, 20'h0);

        // Write and start in the same IDLE cycle: the new word is issued first.
        exp_w[0] = 20'h0ABCD;
        run_prog("load_and_start", 2, 2 * LAT + 2, 2, gd(fw(1)), -1, 1'b1, 20'h0ABCD);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
